// File: rtl/relm_keyq.sv
// -----------------------------------------------------------------------------
// relm_keyq -- key/switch event queue feeding one ReLM core pop port.
//
// The raw key vector is synchronised, debounced as a whole with one shared
// counter, and every committed change becomes an event word in a small
// first-word-fall-through FIFO. Software pops key edges instead of polling
// key levels.
//
// Event word: [NK-1:0] new stable state, [2NK-1:NK] changed-key mask,
//             [2NK] lost (an earlier event was dropped), upper bits zero.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   key_in        raw keys, active-high
//   pop_in        from core pop_out; bit WD is the consume strobe
//   pop_out       to core pop_in; bit WD=1 means empty, WD-1:0 head event
//   overflow_out  sticky: an event was dropped since the last reset
// -----------------------------------------------------------------------------
module relm_keyq #(
  parameter int WD   = 32,
  parameter int NK   = 15,
  parameter int DEB  = 1000,
  parameter int WDEB = 20,
  parameter int WQ   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NK-1:0] key_in,
  input  logic [WD:0]   pop_in,
  output logic [WD:0]   pop_out,
  output logic          overflow_out
);

  localparam int             DEPTH   = 1 << WQ;
  localparam logic [WDEB-1:0] CNT_MAX = WDEB'(DEB - 1);

  // Synchroniser and debounce state
  logic [NK-1:0]   r_sync1, r_sync2, r_cand, r_stable;
  logic [WDEB-1:0] r_cnt;
  logic            r_commit;
  logic [2*NK-1:0] r_evt;      // {changed mask, new state}

  // FIFO state
  logic [WQ:0]     r_wr_ptr, r_rd_ptr;
  logic [WD-1:0]   r_mem [DEPTH];
  logic [WD:0]     r_pop;
  logic            r_pend;     // a drop happened, next accepted event carries lost=1
  logic            r_ovf;

  logic            w_pop, w_full, w_wr_en, w_drop;
  logic [WQ:0]     w_rd_next, w_wr_next;
  logic [WD-1:0]   w_wdata;
  logic [WD:0]     w_pop_next;
  logic            w_unused_pop;

  // Only the strobe bit of the core word is meaningful here.
  assign w_unused_pop = ^pop_in[WD-1:0];

  // ---------------------------------------------------------------------------
  // Synchroniser + debounce. Any difference between the synchronised vector and
  // the candidate restarts the shared counter, so a glitch (or a return to the
  // old value) shorter than DEB cycles never reaches r_stable.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the two-flop synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
      r_commit <= 1'b0;
      r_evt    <= '0;
    end else begin
      r_sync1  <= key_in;
      r_sync2  <= r_sync1;
      r_commit <= 1'b0;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if ((r_cand != r_stable) && (r_cnt == CNT_MAX)) begin
        r_stable <= r_cand;
        r_commit <= 1'b1;
        r_evt    <= {r_cand ^ r_stable, r_cand};
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + WDEB'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control. Occupancy counts the displayed head too, so a consume in the
  // same cycle as a write frees the slot the write needs.
  // ---------------------------------------------------------------------------
  assign w_pop     = pop_in[WD] & ~r_pop[WD];
  assign w_full    = (r_wr_ptr[WQ] != r_rd_ptr[WQ]) &&
                     (r_wr_ptr[WQ-1:0] == r_rd_ptr[WQ-1:0]);
  assign w_wr_en   = r_commit & (~w_full | w_pop);
  assign w_drop    = r_commit & ~w_wr_en;
  assign w_rd_next = r_rd_ptr + (WQ+1)'(w_pop);
  assign w_wr_next = r_wr_ptr + (WQ+1)'(w_wr_en);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_wdata           = '0;
    w_wdata[2*NK-1:0] = r_evt;
    w_wdata[2*NK]     = r_pend;
  end

  // Next head. After a consume the following entry (or empty) shows at once;
  // if the queue held only the consumed head and an event is being written in
  // the same cycle, the new word is forwarded so no empty gap appears. An idle
  // empty head picks up a freshly written entry one cycle after the write.
  always_comb begin
    w_pop_next = r_pop;
    if (w_pop || r_pop[WD]) begin
      if (w_rd_next != r_wr_ptr)
        w_pop_next = {1'b0, r_mem[w_rd_next[WQ-1:0]]};
      else if (w_pop && w_wr_en)
        w_pop_next = {1'b0, w_wdata};
      else
        w_pop_next = {1'b1, {WD{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_pop    <= {1'b1, {WD{1'b0}}};
      r_pend   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_pop    <= w_pop_next;
      if (w_drop) begin
        r_pend <= 1'b1;
        r_ovf  <= 1'b1;
      end else if (w_wr_en) begin
        r_pend <= 1'b0;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which words are valid, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[WQ-1:0]] <= w_wdata;
  end

  assign pop_out      = r_pop;
  assign overflow_out = r_ovf;

endmodule

// File: tb/tb_relm_keyq.sv
module tb_relm_keyq;

  localparam int D = 20;                          // debounce length used here
  localparam logic [32:0] EMPTY = {1'b1, 32'h0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] key_in = '0;
  logic [32:0] pop_in = '0;
  logic [32:0] pop_out;
  logic        overflow_out;

  int n_cmp  = 0;
  int n_fail = 0;

  relm_keyq #(.WD(32), .NK(15), .DEB(D), .WDEB(20), .WQ(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .pop_in       (pop_in),
    .pop_out      (pop_out),
    .overflow_out (overflow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        do_rst;
    logic [14:0] key;
    logic        pop;
    int          ncyc;
    logic [32:0] exp_pop;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then land on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [32:0] mk(input logic lost, input logic [14:0] mask,
                                     input logic [14:0] st);
    logic [32:0] w;
    w        = '0;
    w[14:0]  = st;
    w[29:15] = mask;
    w[30]    = lost;
    return w;
  endfunction

  task automatic do_reset();
    rst    = 1'b1;
    key_in = '0;
    pop_in = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic pop1();
    pop_in[32] = 1'b1;
    tick(1);
    pop_in[32] = 1'b0;
  endtask

  vec_t        vt[13];
  logic [32:0] q[$];
  logic [32:0] w;
  int          bad;

  initial begin
    vt[0]  = '{"reset_idle",    1'b0, 15'h0000, 1'b0, 3,      EMPTY,          1'b0};
    vt[1]  = '{"before_lat",    1'b0, 15'h0001, 1'b0, D + 4,  EMPTY,          1'b0};
    vt[2]  = '{"at_lat",        1'b0, 15'h0001, 1'b0, 1,      33'h0_00008001, 1'b0};
    vt[3]  = '{"head_held",     1'b0, 15'h0001, 1'b0, 5,      33'h0_00008001, 1'b0};
    vt[4]  = '{"pop_to_empty",  1'b0, 15'h0001, 1'b1, 1,      EMPTY,          1'b0};
    vt[5]  = '{"stay_empty",    1'b0, 15'h0001, 1'b0, 3,      EMPTY,          1'b0};
    vt[6]  = '{"glitch_on",     1'b0, 15'h0009, 1'b0, D - 2,  EMPTY,          1'b0};
    vt[7]  = '{"glitch_gone",   1'b0, 15'h0001, 1'b0, D + 10, EMPTY,          1'b0};
    vt[8]  = '{"held_thru_rst", 1'b1, 15'h0001, 1'b0, D + 10, 33'h0_00008001, 1'b0};
    vt[9]  = '{"second_key",    1'b0, 15'h0003, 1'b0, D + 10, 33'h0_00008001, 1'b0};
    vt[10] = '{"pop_second",    1'b0, 15'h0003, 1'b1, 1,      33'h0_00010003, 1'b0};
    vt[11] = '{"pop_last",      1'b0, 15'h0003, 1'b1, 1,      EMPTY,          1'b0};
    vt[12] = '{"idle_after",    1'b0, 15'h0003, 1'b0, 2,      EMPTY,          1'b0};

    do_reset();
    check("reset_pop_out", 64'(pop_out), 64'(EMPTY));
    check("reset_ovf", 64'(overflow_out), 64'd0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 13; i++) begin
      key_in = vt[i].key;
      pop_in = {vt[i].pop, 32'h0};
      if (vt[i].do_rst) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      tick(vt[i].ncyc);
      check({vt[i].name, "_pop"}, 64'(pop_out), 64'(vt[i].exp_pop));
      check({vt[i].name, "_ovf"}, 64'(overflow_out), 64'(vt[i].exp_ovf));
    end
    pop_in = '0;

    // ---- overflow: 17 events, 16 kept, then lost flag on the next one ----
    do_reset();
    q.delete();
    for (int i = 1; i <= 17; i++) begin
      key_in[0] = ~key_in[0];
      tick(D + 8);
      if (i <= 16) q.push_back(mk(1'b0, 15'h0001, key_in));
    end
    check("ovf_set", 64'(overflow_out), 64'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_drain%0d", i), 64'(pop_out), 64'(q[i]));
      pop1();
    end
    check("ovf_drained_empty", 64'(pop_out), 64'(EMPTY));
    key_in[0] = ~key_in[0];
    tick(D + 8);
    check("ovf_lost_word", 64'(pop_out), 64'(mk(1'b1, 15'h0001, key_in)));
    pop1();
    key_in[0] = ~key_in[0];
    tick(D + 8);
    check("ovf_lost_cleared", 64'(pop_out), 64'(mk(1'b0, 15'h0001, key_in)));
    pop1();
    check("ovf_final_empty", 64'(pop_out), 64'(EMPTY));
    check("ovf_sticky", 64'(overflow_out), 64'd1);

    // ---- full queue: write and consume in the same cycle ----
    do_reset();
    q.delete();
    for (int i = 1; i <= 16; i++) begin
      key_in[0] = ~key_in[0];
      tick(D + 8);
      q.push_back(mk(1'b0, 15'h0001, key_in));
    end
    check("full_head", 64'(pop_out), 64'(q[0]));
    key_in[0] = ~key_in[0];
    tick(D + 3);              // event is committed, its write is on the next edge
    pop_in[32] = 1'b1;
    tick(1);
    pop_in[32] = 1'b0;
    q.push_back(mk(1'b0, 15'h0001, key_in));
    void'(q.pop_front());
    tick(3);
    check("full_simul_no_ovf", 64'(overflow_out), 64'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_drain%0d", i), 64'(pop_out), 64'(q[i]));
      pop1();
    end
    check("full_drained_empty", 64'(pop_out), 64'(EMPTY));

    // ---- async reset with entries queued and a debounce in progress ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      key_in[0] = ~key_in[0];
      tick(D + 8);
    end
    check("pre_rst_head", 64'(pop_out), 64'(mk(1'b0, 15'h0001, 15'h0001)));
    key_in[0] = ~key_in[0];
    tick(D / 2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pop", 64'(pop_out), 64'(EMPTY));
    check("async_rst_ovf", 64'(overflow_out), 64'd0);
    key_in = '0;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3 * D; i++) begin
      tick(0);
      @(negedge clk);
      w = pop_out;
      if (w !== EMPTY) bad++;
    end
    check("post_rst_no_event", 64'(bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/relm_keyq.md
Name: relm_keyq

Overview:
- Input-side pop-port stage for the ReLM core.
- Synchronises and debounces the board key/switch vector. Each debounced change becomes one event word in a small FIFO.
- Presents the FIFO head to one core pop port, so software reads key edges instead of polling levels.
- Sits between the board pins and one NPOP slot of the core, replacing the bare key register.

Parameters:
- WD, 32: core data width; port words are WD+1 bits.
- NK, 15: number of key/switch inputs; 2*NK+1 <= WD.
- DEB, 1000: cycles an input vector must stay unchanged before it is committed; 1..2**WDEB-1.
- WDEB, 20: debounce counter width.
- WQ, 4: log2 of FIFO depth (16 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- key_in  in  NK  raw keys, active-high (pin inversion done by the instantiating top).
- pop_in  in  WD+1  from core pop_out; bit WD = consume strobe, other bits ignored.
- pop_out  out  WD+1  to core pop_in; bit WD = 1 means empty/retry; bits WD-1:0 = head event word.
- overflow_out  out  1  sticky flag: an event was dropped since the last reset.

Behaviour:
- Reset: asynchronous, active-high; all state clears while rst=1.
  - sync, cand, stable, counter: 0.
  - FIFO pointers: 0.
  - Pending-overflow flag: 0.
  - pop_out = {1'b1, WD'b0}; overflow_out = 0.
- Synchroniser: two flops, sync2 <= sync1 <= key_in.
- Debounce, one shared counter cnt for the whole vector:
  - If sync2 != cand: cand <= sync2, cnt <= 0.
  - Else if cand != stable and cnt == DEB-1: stable <= cand, raise commit for one cycle. The commit registers the event word.
  - Else if cnt != DEB-1: cnt <= cnt+1.
  - A glitch shorter than DEB cycles never commits.
  - If the vector returns to its old value before commit, no event is produced.
- Event word:
  - bits NK-1:0 = new stable.
  - bits 2NK-1:NK = stable XOR previous stable (never zero).
  - bit 2NK = lost flag: at least one event was dropped before this one.
  - upper bits = 0.
- FIFO: depth 2**WQ, pointers WQ+1 bits wide, registered output, first-word-fall-through.
  - A committed event is written at the edge after commit.
  - It appears on pop_out at the following edge with pop_out[WD]=0.
  - Latency from key_in change (held stable) to pop_out[WD]=0: DEB+5 cycles.
- Consume:
  - pop_in[WD]=1 while pop_out[WD]=0 advances the head.
  - The next entry, or empty, is shown on the next cycle.
  - pop_in[WD]=1 while empty is ignored; pointers are unchanged.
- Full:
  - An event arriving while full with no same-cycle consume is dropped.
  - A drop sets the pending-overflow flag and overflow_out (sticky until reset).
  - The next accepted event carries lost=1; the pending flag then clears.
- Simultaneous consume and write:
  - When full, both complete and occupancy stays full.
  - When holding one entry, the new event becomes head next cycle; no empty gap.
- Ordering: events are strictly FIFO, with no merging.
- Keys held through reset produce one event DEB+5 cycles after rst falls, because stable restarts at 0.
- Reset asserted mid-debounce or with entries queued discards everything; no partial event is emitted.

Test Plan:
- Reset, then key_in=15'h0001 held: pop_out=33'h1_00000000 until cycle DEB+5 after the change. Then pop_out=33'h0_00008001 (mask 0x0001<<15 | state 0x0001). After a pop_in[32] strobe, pop_out returns to empty.
- Pulse key_in[3] high for DEB-2 cycles: no event ever appears; pop_out[32] stays 1.
- Hold key_in[0] high, then key_in[1] high DEB+10 cycles later, with no pops: two events in order, 0x00008001 then 0x00010003.
- Generate 17 toggle events without consuming: first 16 queued, 17th dropped, overflow_out=1. Drain 16 entries, then create one more change: its word has bit 30 set. The change after that has bit 30 clear.
- FIFO full with head present: a commit and a pop_in strobe in the same cycle; occupancy stays 16 and no lost flag is set.
- Assert rst asynchronously with 3 entries queued and a debounce in progress: pop_out goes to 33'h1_00000000 immediately. After release with key_in=0, no events appear.
